// File: rtl/tmds_link_if.sv
// ---------------------------------------------------------------------------
// tmds_link_if
//   Bundles the parallel pixel-side inputs and the encoded symbol outputs of
//   tmds_link_encoder.
//
//   Parameter:
//     NUM_CH   number of TMDS data channels (1..4)
//
//   Signals:
//     mode      [2:0]          period type for the current pixel
//     data_in   [8*NUM_CH-1:0] video byte per channel, channel n at [8n+7:8n]
//     terc4_in  [4*NUM_CH-1:0] data-island nibble per channel
//     ctrl_in   [2*NUM_CH-1:0] control bits {C1,C0} per channel
//     tmds_out  [10*NUM_CH-1:0] registered 10-bit symbol per channel, bit 0 first
//     bias_out  [5*NUM_CH-1:0] signed running disparity per channel (debug)
//
//   Modports:
//     master  pixel source: drives inputs, observes symbols
//     slave   encoder: consumes inputs, drives symbols
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface tmds_link_if #(
   parameter int NUM_CH = 3
);
   logic [2:0]           mode;
   logic [8*NUM_CH-1:0]  data_in;
   logic [4*NUM_CH-1:0]  terc4_in;
   logic [2*NUM_CH-1:0]  ctrl_in;
   logic [10*NUM_CH-1:0] tmds_out;
   logic [5*NUM_CH-1:0]  bias_out;

   modport master (
      output mode,
      output data_in,
      output terc4_in,
      output ctrl_in,
      input  tmds_out,
      input  bias_out
   );

   modport slave (
      input  mode,
      input  data_in,
      input  terc4_in,
      input  ctrl_in,
      output tmds_out,
      output bias_out
   );
endinterface

// File: rtl/tmds_link_encoder.sv
// ---------------------------------------------------------------------------
// tmds_link_encoder
//   Multi-channel TMDS (DVI/HDMI) symbol encoder, two pipeline stages.
//     Stage A: registers mode, control bits, TERC4 nibbles and the 9-bit
//              transition-minimised word q_m of each channel.
//     Stage B: picks the output symbol for the period type (DC-balanced
//              video, control, guard band, TERC4) and registers it together
//              with the per-channel running disparity.
//   Latency is two clocks from input sample to tmds_out, one symbol per
//   channel per clock, no stall.
//
//   Parameters:
//     NUM_CH       number of data channels encoded in parallel (1..4)
//     CH0_IS_SYNC  1: channel 0 carries TERC4 {1,1,C1,C0} in the data-island
//                  guard band; 0: channel 0 sends the plain guard band
//
//   Ports:
//     clk    pixel clock, rising edge
//     rst_n  asynchronous active-low reset, clears every register
//     link   tmds_link_if.slave (mode, data_in, terc4_in, ctrl_in in;
//            tmds_out, bias_out out)
//
//   Build option:
//     TMDS_TERC4_EN  when defined, modes 3 (TERC4 data island) and 4
//                    (data-island guard band) are encoded; when undefined
//                    the TERC4 logic is left out, both modes fall back to
//                    control symbols and terc4_in is ignored.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tmds_link_encoder #(
   parameter int NUM_CH      = 3,
   parameter int CH0_IS_SYNC = 1
) (
   input logic        clk,
   input logic        rst_n,
   tmds_link_if.slave link
);

   localparam logic [2:0] MODE_VIDEO   = 3'd1;
   localparam logic [2:0] MODE_VGUARD  = 3'd2;
`ifdef TMDS_TERC4_EN
   localparam logic [2:0] MODE_TERC4   = 3'd3;
   localparam logic [2:0] MODE_DIGUARD = 3'd4;
`endif

   // Guard-band patterns: GB_A on even channels of the video guard band,
   // GB_B on odd channels and on the data-island guard band.
   localparam logic [9:0] GB_A = 10'b1011001100;
   localparam logic [9:0] GB_B = 10'b0100110011;

   typedef struct packed {
      logic [9:0]        sym;
      logic signed [4:0] cnt;
   } bal_t;

   // Transition minimisation: XNOR chain for byte-heavy inputs, XOR otherwise;
   // q_m[8] records which one was used (1 = XOR).
   function automatic logic [8:0] min_trans(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1 = '0;
      for (int i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, d[i]};
      end
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   // DVI DC balance. diff is N1-N0 = 2*N1-8; the 5-bit signed arithmetic
   // may wrap internally but the result is exact because the running
   // disparity never leaves -10..+10.
   function automatic bal_t dc_balance(input logic [8:0] qm,
                                       input logic signed [4:0] cnt);
      logic [3:0]        n1;
      logic signed [4:0] diff;
      logic signed [4:0] two_q8;
      logic signed [4:0] two_nq8;
      bal_t              r;
      n1 = '0;
      for (int i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, qm[i]};
      end
      diff    = $signed({n1, 1'b0}) - 5'sd8;
      two_q8  = qm[8] ? 5'sd2 : 5'sd0;
      two_nq8 = qm[8] ? 5'sd0 : 5'sd2;
      if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
         r.sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         r.cnt = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1 > 4'd4)) ||
                   ((cnt < 5'sd0) && (n1 < 4'd4))) begin
         r.sym = {1'b1, qm[8], ~qm[7:0]};
         r.cnt = cnt + two_q8 - diff;
      end else begin
         r.sym = {1'b0, qm[8], qm[7:0]};
         r.cnt = cnt - two_nq8 + diff;
      end
      return r;
   endfunction

   function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

`ifdef TMDS_TERC4_EN
   function automatic logic [9:0] terc4_symbol(input logic [3:0] n);
      logic [9:0] s;
      case (n)
         4'h0:    s = 10'b1010011100;
         4'h1:    s = 10'b1001100011;
         4'h2:    s = 10'b1011100100;
         4'h3:    s = 10'b1011100010;
         4'h4:    s = 10'b0101110001;
         4'h5:    s = 10'b0100011110;
         4'h6:    s = 10'b0110001110;
         4'h7:    s = 10'b0100111100;
         4'h8:    s = 10'b1011001100;
         4'h9:    s = 10'b0100111001;
         4'hA:    s = 10'b0110011100;
         4'hB:    s = 10'b1011000110;
         4'hC:    s = 10'b1010001110;
         4'hD:    s = 10'b1001110001;
         4'hE:    s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction
`endif

   logic [2:0]             mode_d,  mode_q;
   logic [NUM_CH-1:0][1:0] ctrl_d,  ctrl_q;
   logic [NUM_CH-1:0][8:0] qm_d,    qm_q;
`ifdef TMDS_TERC4_EN
   logic [NUM_CH-1:0][3:0] terc4_d, terc4_q;
`else
   logic                   terc4_unused;
   assign terc4_unused = ^link.terc4_in;
`endif
   logic [NUM_CH-1:0][9:0] tmds_d,  tmds_q;
   logic [NUM_CH-1:0][4:0] cnt_d,   cnt_q;

   always_comb begin
      mode_d = link.mode;
      ctrl_d = '0;
      qm_d   = '0;
`ifdef TMDS_TERC4_EN
      terc4_d = '0;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
         ctrl_d[ch] = link.ctrl_in[2*ch +: 2];
         qm_d[ch]   = min_trans(link.data_in[8*ch +: 8]);
`ifdef TMDS_TERC4_EN
         terc4_d[ch] = link.terc4_in[4*ch +: 4];
`endif
      end
   end

   // Stage B symbol select. cnt_d defaults to zero so every non-video cycle
   // clears the running disparity; modes 0 and 5-7 (and 3/4 without TERC4)
   // fall into the control-symbol default.
   always_comb begin
      tmds_d = '0;
      cnt_d  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         case (mode_q)
            MODE_VIDEO: begin
               {tmds_d[ch], cnt_d[ch]} = dc_balance(qm_q[ch], $signed(cnt_q[ch]));
            end
            MODE_VGUARD: begin
               tmds_d[ch] = ((ch == 1) || (ch == 3)) ? GB_B : GB_A;
            end
`ifdef TMDS_TERC4_EN
            MODE_TERC4: begin
               tmds_d[ch] = terc4_symbol(terc4_q[ch]);
            end
            MODE_DIGUARD: begin
               if ((ch == 0) && (CH0_IS_SYNC != 0)) begin
                  tmds_d[ch] = terc4_symbol({2'b11, ctrl_q[ch]});
               end else begin
                  tmds_d[ch] = GB_B;
               end
            end
`endif
            default: begin
               tmds_d[ch] = ctrl_symbol(ctrl_q[ch]);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= '0;
         ctrl_q  <= '0;
         qm_q    <= '0;
`ifdef TMDS_TERC4_EN
         terc4_q <= '0;
`endif
         tmds_q  <= '0;
         cnt_q   <= '0;
      end else begin
         mode_q  <= mode_d;
         ctrl_q  <= ctrl_d;
         qm_q    <= qm_d;
`ifdef TMDS_TERC4_EN
         terc4_q <= terc4_d;
`endif
         tmds_q  <= tmds_d;
         cnt_q   <= cnt_d;
      end
   end

   assign link.tmds_out = tmds_q;
   assign link.bias_out = cnt_q;

endmodule

// File: tb/tb_tmds_link_encoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_link_encoder
//   Self-checking bench for tmds_link_encoder (NUM_CH=3, CH0_IS_SYNC=1).
//   Every driven input pushes its expected symbols/bias into a queue,
//   computed by a reference model written from the TMDS encoding rules;
//   a monitor pops and compares when each entry's output is due.
//   Honours TMDS_TERC4_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tmds_link_encoder;
   localparam int NUM_CH      = 3;
   localparam int CH0_IS_SYNC = 1;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   tmds_link_if #(.NUM_CH(NUM_CH)) link ();

   tmds_link_encoder #(.NUM_CH(NUM_CH), .CH0_IS_SYNC(CH0_IS_SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .link  (link)
   );

   typedef struct {
      logic [10*NUM_CH-1:0] tmds;
      logic [5*NUM_CH-1:0]  bias;
      int                   due;
   } exp_t;

   exp_t sbQ[$];
   exp_t monEntry;
   int   total = 0;
   int   bad = 0;
   int   posCount = 0;
   int   modelCnt[NUM_CH];

   logic [9:0] ctrlTbl[4] = '{10'b1101010100, 10'b0010101011,
                              10'b0101010100, 10'b1010101011};
   logic [9:0] terc4Tbl[16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   always @(posedge clk) posCount <= posCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int ones8(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // Each XOR-chain bit is the parity of the input bits up to it; the XNOR
   // chain additionally flips every odd position.
   function automatic logic [8:0] refQm(input logic [7:0] d);
      int         n = ones8(d);
      bit         useXnor = (n > 4) || (n == 4 && d[0] == 1'b0);
      logic [8:0] q;
      for (int i = 0; i < 8; i++) begin
         int p = ones8(d & 8'((1 << (i + 1)) - 1));
         q[i] = p[0] ^ (useXnor && (i % 2 == 1));
      end
      q[8] = !useXnor;
      return q;
   endfunction

   function automatic logic [9:0] refSymbol(input int ch, input logic [2:0] m,
                                            input logic [7:0] d, input logic [3:0] nib,
                                            input logic [1:0] c);
      int         md = int'(m);
      logic [9:0] sym;
      logic [8:0] qm;
      int         n1, n0, cnt;
`ifndef TMDS_TERC4_EN
      if (md == 3 || md == 4) md = 0;
`endif
      if (md != 1) modelCnt[ch] = 0;
      case (md)
         1: begin
            qm  = refQm(d);
            n1  = ones8(qm[7:0]);
            n0  = 8 - n1;
            cnt = modelCnt[ch];
            if (cnt == 0 || n1 == n0) begin
               sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
               cnt += qm[8] ? (n1 - n0) : (n0 - n1);
            end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
               sym = {1'b1, qm[8], ~qm[7:0]};
               cnt += (qm[8] ? 2 : 0) + n0 - n1;
            end else begin
               sym = {1'b0, qm[8], qm[7:0]};
               cnt += (qm[8] ? 0 : -2) + n1 - n0;
            end
            modelCnt[ch] = cnt;
         end
         2: sym = (ch == 1 || ch == 3) ? 10'b0100110011 : 10'b1011001100;
         3: sym = terc4Tbl[nib];
         4: sym = (ch == 0 && CH0_IS_SYNC != 0) ? terc4Tbl[{2'b11, c}] : 10'b0100110011;
         default: sym = ctrlTbl[c];
      endcase
      return sym;
   endfunction

   task automatic driveNow(input logic [2:0] m, input logic [8*NUM_CH-1:0] d,
                           input logic [4*NUM_CH-1:0] nib, input logic [2*NUM_CH-1:0] c);
      exp_t e;
      link.mode     = m;
      link.data_in  = d;
      link.terc4_in = nib;
      link.ctrl_in  = c;
      e.due = posCount + 2;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         e.tmds[10*ch +: 10] = refSymbol(ch, m, d[8*ch +: 8], nib[4*ch +: 4], c[2*ch +: 2]);
         e.bias[5*ch +: 5]   = 5'(modelCnt[ch]);
      end
      sbQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [2:0] m, input logic [8*NUM_CH-1:0] d,
                                input logic [4*NUM_CH-1:0] nib, input logic [2*NUM_CH-1:0] c);
      @(posedge clk);
      #2;
      driveNow(m, d, nib, c);
   endtask

   task automatic idleCtrl();
      applyStimulus(3'd0, '0, '0, '0);
   endtask

   task automatic applyReset(input int cycles);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_tmds", link.tmds_out, '0);
      checkOutput("reset_bias", link.bias_out, '0);
      sbQ.delete();
      for (int ch = 0; ch < NUM_CH; ch++) modelCnt[ch] = 0;
      repeat (cycles) @(posedge clk);
      #2;
      rst_n = 1'b1;
      driveNow(3'd0, '0, '0, '0);
      idleCtrl();
      idleCtrl();
      checkOutput("release_ctrl00", link.tmds_out, {NUM_CH{10'b1101010100}});
   endtask

   // Scoreboard monitor: compares each queued expectation on the falling
   // edge after the rising edge that should have produced it.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         while (sbQ.size() > 0 && sbQ[0].due <= posCount) begin
            monEntry = sbQ.pop_front();
            if (monEntry.due != posCount) begin
               checkOutput("sb_due", 64'(posCount), 64'(monEntry.due));
            end else begin
               checkOutput("sb_tmds", link.tmds_out, monEntry.tmds);
               checkOutput("sb_bias", link.bias_out, monEntry.bias);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [2:0] m;
      for (int ch = 0; ch < NUM_CH; ch++) modelCnt[ch] = 0;
      link.mode = '0;
      link.data_in = '0;
      link.terc4_in = '0;
      link.ctrl_in = '0;
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("por_tmds", link.tmds_out, '0);
      checkOutput("por_bias", link.bias_out, '0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      driveNow(3'd0, '0, '0, '0);
      idleCtrl();
      idleCtrl();
      checkOutput("first_ctrl00", link.tmds_out, {NUM_CH{10'b1101010100}});

      // DC balance from neutral disparity: 0x00 twice
      applyStimulus(3'd1, '0, '0, '0);
      applyStimulus(3'd1, '0, '0, '0);
      idleCtrl();
      checkOutput("dc_first_sym", link.tmds_out, {NUM_CH{10'b0100000000}});
      checkOutput("dc_first_bias", link.bias_out, {NUM_CH{5'b11000}});
      idleCtrl();
      checkOutput("dc_second_sym", link.tmds_out, {NUM_CH{10'b1111111111}});
      checkOutput("dc_second_bias", link.bias_out, {NUM_CH{5'b00010}});

      // Bias clear by one control cycle, then neutral branch again
      repeat (4) applyStimulus(3'd1, '0, '0, '0);
      applyStimulus(3'd0, '0, '0, 6'b01_10_11);
      applyStimulus(3'd1, '0, '0, '0);
      idleCtrl();
      checkOutput("clear_bias", link.bias_out, '0);
      idleCtrl();
      checkOutput("clear_neutral_sym", link.tmds_out, {NUM_CH{10'b0100000000}});
      checkOutput("clear_neutral_bias", link.bias_out, {NUM_CH{5'b11000}});

      // Guard bands
      applyStimulus(3'd2, 24'hA5C33C, '0, '0);
      idleCtrl();
      idleCtrl();
      checkOutput("video_guard", link.tmds_out, {10'b1011001100, 10'b0100110011, 10'b1011001100});
      applyStimulus(3'd4, '0, '0, 6'b11_11_11);
      idleCtrl();
      idleCtrl();
`ifdef TMDS_TERC4_EN
      checkOutput("di_guard_ch0", link.tmds_out[9:0], 10'b1011000011);
`else
      checkOutput("di_guard_ch0", link.tmds_out[9:0], 10'b1010101011);
`endif

      // TERC4 nibbles 0x0 / 0x8 / 0xF on channels 0 / 1 / 2
      applyStimulus(3'd3, '0, 12'hF80, '0);
      idleCtrl();
      idleCtrl();
`ifdef TMDS_TERC4_EN
      checkOutput("terc4", link.tmds_out, {10'b1011000011, 10'b1011001100, 10'b1010011100});
`else
      checkOutput("terc4", link.tmds_out, {NUM_CH{10'b1101010100}});
`endif

      // Latency: mode alternating control/video every cycle
      for (int i = 0; i < 24; i++) begin
         applyStimulus((i % 2 == 0) ? 3'd0 : 3'd1, 24'($urandom), 12'($urandom), 6'($urandom));
      end

      // Reset asserted mid-video
      repeat (5) applyStimulus(3'd1, 24'($urandom), '0, '0);
      applyReset(2);

      // Randomised traffic, video-heavy so the disparity wanders
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) m = 3'd1;
         else m = 3'($urandom_range(0, 7));
         applyStimulus(m, 24'($urandom), 12'($urandom), 6'($urandom));
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tmds_link_encoder.md
TMDS_LINK_ENCODER -- requirements
Module: tmds_link_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of TMDS data channels encoded in parallel (legal 1..4).
REQ-002 SHALL have parameter CH0_IS_SYNC, default 1, meaning channel 0 carries HSYNC/VSYNC in data-island guard band.
REQ-003 SHALL have port clk  input  1  pixel clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  3  period type: 0 control, 1 video data, 2 video guard band, 3 TERC4 data island, 4 data-island guard band; 5-7 treated as control.
REQ-006 SHALL have port data_in  input  8*NUM_CH  video byte per channel, channel n at [8n+7:8n].
REQ-007 SHALL have port terc4_in  input  4*NUM_CH  data-island nibble per channel.
REQ-008 SHALL have port ctrl_in  input  2*NUM_CH  control bits {C1,C0} per channel.
REQ-009 SHALL have port tmds_out  output  10*NUM_CH  registered 10-bit symbol per channel, bit 0 transmitted first.
REQ-010 SHALL have port bias_out  output  5*NUM_CH  signed running disparity per channel, for debug.

Function
REQ-011 SHALL be a 2-stage pipeline: stage A registers mode, ctrl, terc4 and the 9-bit transition-minimised word q_m; stage B computes balanced symbol and registers tmds_out.
REQ-012 SHALL have latency exactly 2 cycles from any input sample to tmds_out, with throughput one symbol per channel per cycle and no stall.
REQ-013 SHALL form q_m with XNOR when ones(d)>4 or (ones(d)==4 and d[0]==0), otherwise XOR; q_m[8]=1 for XOR, 0 for XNOR.
REQ-014 SHALL, in video data mode, apply standard DVI DC balance per channel using 5-bit signed bias cnt.
- cnt==0 or N1==N0: out[9]=~q_m[8], out[8]=q_m[8], out[7:0]=q_m[8]?q_m:~q_m, cnt += q_m[8]?(N1-N0):(N0-N1).
- Same sign (cnt>0,N1>N0 or cnt<0,N0>N1): out[9]=1, invert [7:0], cnt += 2*q_m[8]+(N0-N1).
- Else: out[9]=0, no invert, cnt += -2*~q_m[8]+(N1-N0).
REQ-015 SHALL emit control symbols {C1,C0}: 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011 (bit9..bit0).
REQ-016 SHALL emit video guard band 1011001100 on channels 0 and 2, 0100110011 on channel 1, channel 3 uses channel 1 value.
REQ-017 SHALL encode TERC4 nibbles with the HDMI 1.4 TERC4 table (e.g. 0x0=1010011100, 0x8=1011001100, 0xF=1011000011).
REQ-018 SHALL emit data-island guard band 0100110011 on channels 1..NUM_CH-1; channel 0 emits TERC4 of {1,1,C1,C0} when CH0_IS_SYNC=1, else 0100110011.
REQ-019 SHALL clear each channel's cnt to 0 on every stage-B cycle whose mode is not video data.
REQ-020 SHALL preserve cnt across consecutive video-data cycles with no saturation; cnt stays within -10..+10 by construction.
REQ-021 SHALL keep channels independent; each channel's bias depends only on its own data.

Reset
REQ-022 SHALL, while rst_n low, drive tmds_out all zero, bias_out zero, all pipeline registers and cnt zero.
REQ-023 SHALL, on rst_n deassertion mid-stream, produce first valid symbols 2 cycles after the first sampled input; no partial stage-A data retained.

Configuration
REQ-024 SHALL honour macro TMDS_TERC4_EN: defined, modes 3 and 4 behave per REQ-017/REQ-018.
REQ-025 SHALL, without TMDS_TERC4_EN, omit TERC4 logic and treat modes 3 and 4 as control (REQ-015), terc4_in unused.

Verification
REQ-026 SHALL cover reset: rst_n low mid-video -> tmds_out=0, bias_out=0 same cycle; release, mode=0 ctrl=00 -> 1101010100 two cycles later.
REQ-027 SHALL cover DC balance: after control, data_in=0x00 on channel 0 for 2 cycles -> 0100000000 (cnt=-8), then 1111111111 (cnt=+2).
REQ-028 SHALL cover bias clear: video data building cnt!=0, one control cycle, then video -> bias_out 0 after control, next symbol uses neutral branch.
REQ-029 SHALL cover guard bands: mode=2 -> ch0=1011001100, ch1=0100110011, ch2=1011001100; mode=4 ctrl ch0=11 -> ch0=1011000011.
REQ-030 SHALL cover TERC4: mode=3 nibbles 0x0/0x8/0xF -> 1010011100/1011001100/1011000011; macro undefined, same stimulus -> control symbols.
REQ-031 SHALL cover latency: mode toggling every cycle between 0 and 1 -> each output symbol matches input from exactly 2 cycles earlier.
